// File: rtl/sample_player_pkg.sv
// sample_player_pkg: shared types and constants for the sample playback source.
//   state_t  - playback FSM states
//   RATE_MIN - smallest effective rate divider (issue period = rate + 1 cycles)
package sample_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned RATE_MIN = 1;

endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port sample memory, one write port and one
// synchronous read port (1-cycle latency). A read and a write to the same
// address on the same edge return the old contents. Contents are not reset.
//   clk                       - clock
//   wr_en, wr_addr, wr_data   - write port
//   rd_en, rd_addr            - read request
//   rd_data                   - read data, valid the cycle after rd_en
module sample_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, giving read-old-data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_player.sv
// sample_player: plays stored signed samples out on a valid/ready stream at a
// programmable rate, one-shot or looping.
//   clk, rst                     - clock, async active-high reset
//   wr_en, wr_addr, wr_data      - sample memory load port (any state)
//   start, stop                  - begin (IDLE only) / abort (RUN only)
//   loop_mode, last_addr         - wrap after last_addr, or stop there
//   rate_div                     - issue period = max(rate_div,1)+1 cycles
//   dout, dout_valid, dout_ready - output sample stream
//   busy, wrap, done             - status: not idle, address wrapped, finished
module sample_player
  import sample_player_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [ADDR_W-1:0] last_lat, last_lat_nxt;
  logic              loop_lat, loop_lat_nxt;
  logic [DIV_W-1:0]  rate_lat, rate_lat_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic              rd_pend, rd_pend_nxt;
  logic              tick_pend, tick_pend_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              dout_valid_nxt;
  logic              wrap_nxt, done_nxt;
  logic              tick_c, issue_c;
  logic [DATA_W-1:0] ram_q;

  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue_c),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      last_lat   <= '0;
      loop_lat   <= 1'b0;
      rate_lat   <= '0;
      div_cnt    <= '0;
      rd_pend    <= 1'b0;
      tick_pend  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_addr    <= rd_addr_nxt;
      last_lat   <= last_lat_nxt;
      loop_lat   <= loop_lat_nxt;
      rate_lat   <= rate_lat_nxt;
      div_cnt    <= div_cnt_nxt;
      rd_pend    <= rd_pend_nxt;
      tick_pend  <= tick_pend_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      busy       <= (state_nxt != IDLE);
      wrap       <= wrap_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state, rate counter, address counter and output register logic.
  always_comb begin
    state_nxt      = state;
    rd_addr_nxt    = rd_addr;
    last_lat_nxt   = last_lat;
    loop_lat_nxt   = loop_lat;
    rate_lat_nxt   = rate_lat;
    div_cnt_nxt    = div_cnt;
    rd_pend_nxt    = rd_pend;
    tick_pend_nxt  = tick_pend;
    dout_nxt       = dout;
    dout_valid_nxt = dout_valid;
    wrap_nxt       = 1'b0;
    done_nxt       = 1'b0;
    issue_c        = 1'b0;
    tick_c         = (div_cnt == '0);

    // Output register runs in every state so in-flight reads always land.
    // An issue is only allowed when the register will be free, so a
    // completing read never overwrites an unaccepted sample.
    if (rd_pend) begin
      dout_nxt       = ram_q;
      dout_valid_nxt = 1'b1;
      rd_pend_nxt    = 1'b0;
    end else if (dout_valid && dout_ready) begin
      dout_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = RUN;
          loop_lat_nxt  = loop_mode;
          last_lat_nxt  = last_addr;
          rate_lat_nxt  = (rate_div < DIV_W'(RATE_MIN)) ? DIV_W'(RATE_MIN) : rate_div;
          rd_addr_nxt   = '0;
          div_cnt_nxt   = '0;
          tick_pend_nxt = 1'b0;
        end
      end

      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else begin
          div_cnt_nxt = tick_c ? rate_lat : div_cnt - DIV_W'(1);
          issue_c     = (tick_c || tick_pend) && !rd_pend && (!dout_valid || dout_ready);
          if (issue_c) begin
            rd_pend_nxt   = 1'b1;
            tick_pend_nxt = 1'b0;
            if (rd_addr == last_lat) begin
              if (loop_lat) begin
                rd_addr_nxt = '0;
                wrap_nxt    = 1'b1;
              end else begin
                state_nxt = DRAIN;
              end
            end else begin
              rd_addr_nxt = rd_addr + ADDR_W'(1);
            end
          end else if (tick_c) begin
            // Missed tick is remembered so no sample is skipped.
            tick_pend_nxt = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!rd_pend && (!dout_valid || dout_ready)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sample_player.sv
// tb_sample_player: directed bench for sample_player. A stream scoreboard
// predicts every accepted sample from a memory image and the playback mode,
// and checks hold-stability under backpressure; directed tests pin latency,
// spacing, wrap/done timing and data values with literal expectations.
module tb_sample_player;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DIV_W  = 16;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              stop;
  logic              loop_mode;
  logic [ADDR_W-1:0] last_addr;
  logic [DIV_W-1:0]  rate_div;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              wrap;
  logic              done;

  sample_player #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .loop_mode  (loop_mode),
    .last_addr  (last_addr),
    .rate_div   (rate_div),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .wrap       (wrap),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream model state.
  logic [DATA_W-1:0] sb_mem [1024];
  bit                sb_on = 1'b0;
  int                exp_idx = 0;
  int                exp_last = 0;
  bit                exp_loop = 1'b0;
  bit                exp_end = 1'b0;
  logic [DATA_W-1:0] hs_q[$];
  int                hs_cyc[$];
  int                rise_q[$];
  int                wrap_q[$];
  int                done_q[$];
  bit                prev_hold = 1'b0;
  bit                prev_valid = 1'b0;
  logic [DATA_W-1:0] prev_dout = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (prev_hold) begin
        chk("hold_valid", int'(dout_valid), 1);
        chk("hold_data", int'(dout), int'(prev_dout));
      end
      if (dout_valid && dout_ready) begin
        chk("no_overrun", int'(exp_end), 0);
        chk("stream_data", int'(dout), int'(sb_mem[exp_idx]));
        hs_q.push_back(dout);
        hs_cyc.push_back(cyc);
        if (exp_idx == exp_last) begin
          if (exp_loop) exp_idx = 0;
          else exp_end = 1'b1;
        end else begin
          exp_idx++;
        end
      end
      if (dout_valid && !prev_valid) rise_q.push_back(cyc);
      if (wrap) wrap_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
    end
    prev_hold  = dout_valid && !dout_ready;
    prev_valid = dout_valid;
    prev_dout  = dout;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = DATA_W'(d);
    step();
    wr_en   = 1'b0;
    sb_mem[a] = DATA_W'(d);
  endtask

  // Start edge E0 is the first edge inside this task.
  task automatic play(input bit lp, input int last, input int rate);
    hs_q.delete(); hs_cyc.delete(); rise_q.delete(); wrap_q.delete(); done_q.delete();
    exp_idx = 0; exp_last = last; exp_loop = lp; exp_end = 1'b0; sb_on = 1'b1;
    loop_mode = lp;
    last_addr = ADDR_W'(last);
    rate_div  = DIV_W'(rate);
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_hs(input string name, input int n, input int budget);
    for (int i = 0; i < budget && hs_q.size() < n; i++) step();
    chk(name, int'(hs_q.size() >= n), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_q.size() < 1; i++) step();
    step(); step(); step();
    chk(name, done_q.size(), 1);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n3;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_mode = 1'b0; last_addr = '0;
    rate_div = '0; dout_ready = 1'b1;
    #2;
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_done", int'(done), 0);
    #20 rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) write_mem(i, i);

    // One-shot, 8 samples, rate 3 -> 4-cycle spacing.
    play(1'b0, 7, 3);
    chk("t1_busy_run", int'(busy), 1);
    wait_done("t1_done", 100);
    chk("t1_count", hs_q.size(), 8);
    chk("t1_latency", rise_q[0] - start_cyc, 2);
    chk("t1_spacing", rise_q[1] - rise_q[0], 4);
    chk("t1_span", hs_cyc[7] - hs_cyc[0], 28);
    chk("t1_last", int'(hs_q[7]), 7);
    chk("t1_done_cyc", done_q[0] - start_cyc, 31);

    // Loop over 0..3 at peak rate, wrap on each issue of address 3, then stop.
    play(1'b1, 3, 1);
    wait_hs("t2_wait", 10, 100);
    stop = 1'b1;
    step();
    stop = 1'b0;
    n0 = hs_q.size();
    wait_done("t2_done", 50);
    chk("t2_stop_tail", int'(hs_q.size() - n0 <= 1), 1);
    chk("t2_wrap0", wrap_q[0] - start_cyc, 7);
    chk("t2_wrap1", wrap_q[1] - start_cyc, 15);
    chk("t2_seq4", int'(hs_q[4]), 0);
    n3 = 0;
    foreach (hs_q[i]) if (hs_q[i] == DATA_W'(3)) n3++;
    chk("t2_wrap_count", wrap_q.size(), n3);

    // Backpressure: ready low for 10 cycles mid-run.
    play(1'b0, 7, 1);
    repeat (5) step();
    dout_ready = 1'b0;
    repeat (10) step();
    dout_ready = 1'b1;
    wait_done("t3_done", 100);
    chk("t3_count", hs_q.size(), 8);
    chk("t3_last", int'(hs_q[7]), 7);

    // rate_div 0 behaves as 1; extreme signed codes pass bit-exact.
    write_mem(0, 12'h800);
    write_mem(1, 12'h7FF);
    play(1'b0, 1, 0);
    wait_done("t4_done", 50);
    chk("t4_count", hs_q.size(), 2);
    chk("t4_latency", rise_q[0] - start_cyc, 2);
    chk("t4_spacing", hs_cyc[1] - hs_cyc[0], 2);
    chk("t4_min", int'($signed(hs_q[0])), -2048);
    chk("t4_max", int'($signed(hs_q[1])), 2047);

    // Asynchronous reset mid-run, off the clock edge.
    play(1'b1, 7, 1);
    repeat (6) step();
    sb_on = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_dout", int'(dout), 0);
    chk("t5_rst_valid", int'(dout_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_wrap", int'(wrap), 0);
    chk("t5_rst_done", int'(done), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    play(1'b0, 3, 1);
    wait_done("t5_done", 50);
    chk("t5_first", int'(hs_q[0]), 12'h800);
    chk("t5_second", int'(hs_q[1]), 12'h7FF);
    chk("t5_third", int'(hs_q[2]), 2);

    // Write to address 5 on the same edge it is read (E21 at rate 3).
    play(1'b1, 7, 3);
    repeat (20) step();
    wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = DATA_W'(12'h0A5);
    step();
    wr_en = 1'b0;
    wait_hs("t6_wait1", 6, 60);
    sb_mem[5] = DATA_W'(12'h0A5);
    wait_hs("t6_wait2", 14, 100);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done("t6_done", 50);
    chk("t6_old", int'(hs_q[5]), 5);
    chk("t6_new", int'(hs_q[13]), 12'h0A5);

    sb_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
